stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control sequencer in front of the stopwatch BCD counter. Synchronises and debounces the board
//  buttons/switches, owns the run/pause/adjust state machine and generates the 1 Hz / 2 Hz
//  single-cycle count enables plus clear, increment and decrement pulses for the counter.
//  Sits between top-level pins and the counter; the counter returns at_limit.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency; even, >= 4
//  DB_CYCLES  500_000      cycles a synchronised input must hold a new value before it is accepted
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  asynchronous, active-high reset
//  btn_pause_raw  in   1  raw pause/run button
//  btn_clr_raw    in   1  raw clear button
//  btn_inc_raw    in   1  raw increment button
//  btn_dec_raw    in   1  raw decrement button
//  sw_adj_raw     in   1  raw adjust-mode switch
//  sw_sel_raw     in   1  raw field select: 1 = seconds, 0 = minutes
//  sw_adjb_raw    in   1  raw adjust style: 1 = button step, 0 = auto 2 Hz
//  sw_dn_raw      in   1  raw count-direction switch: 1 = down
//  at_limit       in   1  from counter: 59:59 when counting up, 00:00 when counting down
//  tick_1hz       out  1  count enable, 1 cycle, RUN state only
//  tick_2hz       out  1  auto-adjust enable, 1 cycle, ADJ state with adj_b=0 only
//  clr            out  1  counter clear pulse, 1 cycle
//  inc_p / dec_p  out  1  adjust step pulses, 1 cycle each
//  adj, sel, adj_b, cnt_dn  out 1 each  debounced switch levels
//  running        out  1  1 while state == RUN
//  blink          out  1  display blink phase
//  state          out  2  STOP=0, RUN=1, PAUSE=2, ADJ=3
// BEHAVIOUR
//  Reset: every output and internal register is 0, state = STOP, divider = 0, debounced levels = 0.
//  Input path, per raw input: 2-FF synchroniser, then a stability counter.
//   - Counter clears whenever the synchronised value equals the debounced level.
//   - When the value differs for DB_CYCLES consecutive cycles, the debounced level takes it.
//   - Buttons: a rising edge of the debounced level gives an internal press pulse one edge later.
//   - Press pulse is high exactly DB_CYCLES+3 edges after the first edge that samples the new raw
//     value. A release produces no pulse.
//  Divider: div_cnt counts 0..CLK_HZ/2-1 and wraps.
//   - Internal t2 fires on the wrap cycle.
//   - Phase bit toggles on every t2; internal t1 = t2 & phase, so the first t1 comes on the 2nd t2.
//   - div_cnt and phase clear in the cycle clr is high, so the next second is full length.
//  FSM. Priority per cycle: adj > clr press > pause press > at_limit.
//   - Any state except ADJ, adj=1 -> ADJ.
//   - ADJ, adj=0 -> PAUSE. Leaving adjust never auto-runs.
//   - Clear press, state not ADJ -> clr=1 for 1 cycle, next state STOP. Ignored in ADJ.
//   - STOP, pause press -> RUN.
//   - PAUSE, pause press -> RUN.
//   - RUN, pause press -> PAUSE.
//   - RUN, at_limit=1 with no higher-priority event -> STOP.
//   - Pause press together with at_limit in RUN -> PAUSE.
//   - STOP, at_limit=1 -> stays STOP; RUN is still entered on a pause press.
//  Outputs:
//   - tick_1hz = t1 & (state==RUN); tick_2hz = t2 & (state==ADJ) & ~adj_b; registered, 1 cycle.
//   - inc_p / dec_p = press & (state==ADJ) & adj_b.
//   - inc and dec press in the same cycle -> neither pulse.
//   - blink toggles on each t2 while in ADJ; forced 0 outside ADJ.
//   - sel and cnt_dn pass through debounced in every state; cnt_dn is not frozen while running.
//  rst asserted mid-operation: immediate return to reset values and discard of in-flight
//  pulses, no clr pulse.
// TESTING (CLK_HZ=8, DB_CYCLES=4)
//  1. Raw pause high at edge 0, held -> one press: STOP->RUN, running=1 at edge 8; a 3-cycle glitch -> no change.
//  2. RUN for 16 cycles -> tick_1hz at edges 8 and 16 relative to divider start, tick_2hz stays 0.
//  3. RUN with at_limit=1 -> STOP next edge, tick_1hz stops. Same with pause press -> PAUSE.
//  4. adj=1, adj_b=1, inc and dec presses -> 1 inc_p, 1 dec_p; simultaneous presses -> none; clr press -> no clr.
//  5. adj=1, adj_b=0 -> tick_2hz every 4 cycles, blink toggles each time; adj=0 -> PAUSE, blink=0.
//  6. Clear press in RUN -> clr 1 cycle, STOP, next tick 8 cycles later; rst mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning, run/pause/adjust FSM,
// 1 Hz / 2 Hz count enables and clear / step pulses for the BCD counter.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause_raw,
    input  logic       btn_clr_raw,
    input  logic       btn_inc_raw,
    input  logic       btn_dec_raw,
    input  logic       sw_adj_raw,
    input  logic       sw_sel_raw,
    input  logic       sw_adjb_raw,
    input  logic       sw_dn_raw,
    input  logic       at_limit,
    output logic       tick_1hz,
    output logic       tick_2hz,
    output logic       clr,
    output logic       inc_p,
    output logic       dec_p,
    output logic       adj,
    output logic       sel,
    output logic       adj_b,
    output logic       cnt_dn,
    output logic       running,
    output logic       blink,
    output logic [1:0] state
);

    localparam int HALF = CLK_HZ / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = $clog2(DB_CYCLES + 1);

    localparam int I_PAUSE = 0;
    localparam int I_CLR   = 1;
    localparam int I_INC   = 2;
    localparam int I_DEC   = 3;
    localparam int I_ADJ   = 4;
    localparam int I_SEL   = 5;
    localparam int I_ADJB  = 6;
    localparam int I_DN    = 7;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ADJ   = 2'd3
    } state_t;

    logic [7:0]    w_raw;
    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [7:0]    r_db;
    logic [CW-1:0] r_cnt [8];
    logic [3:0]    r_db_q;
    logic [3:0]    r_press;

    logic [DW-1:0] r_div;
    logic          r_phase;
    logic          w_t2;
    logic          w_t1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_clr_nxt;
    logic          w_in_adj;

    logic          r_tick1;
    logic          r_tick2;
    logic          r_clr;
    logic          r_inc;
    logic          r_dec;
    logic          r_blink;

    assign w_raw = {sw_dn_raw, sw_adjb_raw, sw_sel_raw, sw_adj_raw,
                    btn_dec_raw, btn_inc_raw, btn_clr_raw, btn_pause_raw};

    // Level is accepted once the synchronised value has differed for DB_CYCLES+1 edges;
    // the press pulse is a registered rising edge of the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_press <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DB_CYCLES)) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_db_q  <= r_db[3:0];
            r_press <= r_db[3:0] & ~r_db_q;
        end
    end

    assign w_t2 = (r_div == DW'(HALF - 1));
    assign w_t1 = w_t2 & r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (r_clr) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (w_t2) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    assign w_in_adj = (r_state == ST_ADJ);

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        if (r_db[I_ADJ]) begin
            w_state_nxt = ST_ADJ;
        end else if (w_in_adj) begin
            w_state_nxt = ST_PAUSE;
        end else if (r_press[I_CLR]) begin
            w_clr_nxt   = 1'b1;
            w_state_nxt = ST_STOP;
        end else if (r_press[I_PAUSE]) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end else if (at_limit && (r_state == ST_RUN)) begin
            w_state_nxt = ST_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
            r_tick1 <= 1'b0;
            r_tick2 <= 1'b0;
            r_clr   <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick1 <= w_t1 & (r_state == ST_RUN);
            r_tick2 <= w_t2 & w_in_adj & ~r_db[I_ADJB];
            r_clr   <= w_clr_nxt;
            r_inc   <= r_press[I_INC] & ~r_press[I_DEC] & w_in_adj & r_db[I_ADJB];
            r_dec   <= r_press[I_DEC] & ~r_press[I_INC] & w_in_adj & r_db[I_ADJB];
            // Blink phase only lives inside ADJ; it drops to 0 on the exit edge.
            r_blink <= (w_state_nxt == ST_ADJ) ? (r_blink ^ (w_t2 & w_in_adj)) : 1'b0;
        end
    end

    assign tick_1hz = r_tick1;
    assign tick_2hz = r_tick2;
    assign clr      = r_clr;
    assign inc_p    = r_inc;
    assign dec_p    = r_dec;
    assign adj      = r_db[I_ADJ];
    assign sel      = r_db[I_SEL];
    assign adj_b    = r_db[I_ADJB];
    assign cnt_dn   = r_db[I_DN];
    assign running  = (r_state == ST_RUN);
    assign blink    = r_blink;
    assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed start-up sequence plus randomized inputs,
// every cycle compared against a sample-window / elapsed-time reference model.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ = 8;
    localparam int DB     = 4;
    localparam int H      = CLK_HZ / 2;
    localparam int WL     = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic       at_lim;
    logic       tick_1hz, tick_2hz, clr, inc_p, dec_p;
    logic       adj, sel, adj_b, cnt_dn, running, blink;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pause_raw(raw[0]),
        .btn_clr_raw  (raw[1]),
        .btn_inc_raw  (raw[2]),
        .btn_dec_raw  (raw[3]),
        .sw_adj_raw   (raw[4]),
        .sw_sel_raw   (raw[5]),
        .sw_adjb_raw  (raw[6]),
        .sw_dn_raw    (raw[7]),
        .at_limit     (at_lim),
        .tick_1hz     (tick_1hz),
        .tick_2hz     (tick_2hz),
        .clr          (clr),
        .inc_p        (inc_p),
        .dec_p        (dec_p),
        .adj          (adj),
        .sel          (sel),
        .adj_b        (adj_b),
        .cnt_dn       (cnt_dn),
        .running      (running),
        .blink        (blink),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Reference model state: raw sample history, accepted levels, press delay line,
    // edges elapsed since the divider last restarted, and the expected outputs.
    logic [7:0] m_hist [WL];
    logic [7:0] m_lvl;
    logic [3:0] m_r1, m_r2;
    int         m_ts;
    int         m_st;
    logic       m_tick1, m_tick2, m_clr, m_inc, m_dec, m_blink;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {3'b000, tick_1hz, tick_2hz, clr, inc_p, dec_p, adj, sel, adj_b, cnt_dn,
                running, blink, state};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [1:0] st;
        st = m_st[1:0];
        return {3'b000, m_tick1, m_tick2, m_clr, m_inc, m_dec, m_lvl[4], m_lvl[5], m_lvl[6],
                m_lvl[7], (m_st == 1), m_blink, st};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < WL; k++) m_hist[k] = '0;
        m_lvl   = '0;
        m_r1    = '0;
        m_r2    = '0;
        m_ts    = 0;
        m_st    = 0;
        m_tick1 = 0; m_tick2 = 0; m_clr = 0; m_inc = 0; m_dec = 0; m_blink = 0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_step();
        logic [3:0] pr;
        logic [3:0] rose;
        logic       t1, t2, flip, clr_n;
        int         nxt;
        pr    = m_r2;
        t2    = ((m_ts % H) == H - 1);
        t1    = (((m_ts + 1) % CLK_HZ) == 0);
        nxt   = m_st;
        clr_n = 1'b0;
        if (m_lvl[4])                nxt = 3;
        else if (m_st == 3)          nxt = 2;
        else if (pr[1])              begin clr_n = 1'b1; nxt = 0; end
        else if (pr[0])              nxt = (m_st == 1) ? 2 : 1;
        else if (at_lim && m_st == 1) nxt = 0;
        m_tick1 = t1 && (m_st == 1);
        m_tick2 = t2 && (m_st == 3) && !m_lvl[6];
        m_inc   = pr[2] && !pr[3] && (m_st == 3) && m_lvl[6];
        m_dec   = pr[3] && !pr[2] && (m_st == 3) && m_lvl[6];
        m_blink = (nxt == 3) ? (m_blink ^ (t2 && (m_st == 3))) : 1'b0;
        m_ts    = m_clr ? 0 : m_ts + 1;
        m_clr   = clr_n;
        for (int k = WL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
        rose = '0;
        for (int i = 0; i < 8; i++) begin
            flip = 1'b1;
            for (int k = 2; k <= DB + 2; k++)
                if (m_hist[k][i] == m_lvl[i]) flip = 1'b0;
            if (flip) begin
                m_lvl[i] = ~m_lvl[i];
                if (i < 4 && m_lvl[i]) rose[i] = 1'b1;
            end
        end
        m_r2 = m_r1;
        m_r1 = rose;
        m_st = nxt;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("outputs", dut_vec(), model_vec());
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check_eq("async_rst", dut_vec(), 16'h0000);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt1, cnt2, len;
        rst    = 1'b1;
        raw    = '0;
        at_lim = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_state", dut_vec(), 16'h0000);
        rst = 1'b0;

        // Pause held from edge 0: RUN must appear at edge 8, not before.
        raw[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            check_eq("press_wait", {15'd0, running}, 16'd0);
        end
        step_cycle();
        check_eq("press_run", {14'd0, state}, 16'd1);
        raw[0] = 1'b0;
        for (int i = 0; i < 8; i++) step_cycle();

        // A 3-cycle glitch is filtered out.
        raw[0] = 1'b1;
        for (int i = 0; i < 3; i++) step_cycle();
        raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) step_cycle();
        check_eq("glitch_run", {14'd0, state}, 16'd1);

        // Any 16 cycles of RUN hold exactly two 1 Hz ticks and no 2 Hz tick.
        cnt1 = 0;
        cnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            step_cycle();
            cnt1 += int'(tick_1hz);
            cnt2 += int'(tick_2hz);
        end
        check_eq("run_1hz", cnt1[15:0], 16'd2);
        check_eq("run_2hz", cnt2[15:0], 16'd0);

        async_reset();

        // Randomized segments of held inputs.
        for (int seg = 0; seg < 320; seg++) begin
            raw[0] = ($urandom_range(0, 2) == 0);
            raw[1] = ($urandom_range(0, 6) == 0);
            raw[2] = ($urandom_range(0, 3) == 0);
            raw[3] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) raw[4] = ~raw[4];
            if ($urandom_range(0, 3) == 0) raw[5] = ~raw[5];
            if ($urandom_range(0, 5) == 0) raw[6] = ~raw[6];
            if ($urandom_range(0, 3) == 0) raw[7] = ~raw[7];
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                at_lim = ($urandom_range(0, 11) == 0);
                step_cycle();
            end
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
